// File: rtl/uart_cmd_parser.sv
// Decodes 6-byte host command frames (A5 CMD D0 D1 CHK 5A) from the UART receiver
// and drives the runtime configuration registers, with accept/reject pulses and error count.
module uart_cmd_parser #(
  parameter int unsigned TIMEOUT_CYC = 1_000_000,
  parameter int unsigned X_LIMIT     = 320,
  parameter int unsigned Y_LIMIT     = 240
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx_done,
  input  logic [7:0] rx_data,
  output logic       traffic_sel,
  output logic       sw_sel,
  output logic       manual_en,
  output logic       manual_light,
  output logic       coord_ovr_en,
  output logic [9:0] x_min_ovr,
  output logic [9:0] x_max_ovr,
  output logic [9:0] y_min_ovr,
  output logic [9:0] y_max_ovr,
  output logic       cmd_ok,
  output logic       cmd_err,
  output logic [7:0] err_count
);

  localparam int unsigned TW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;

  localparam logic [7:0] SOF_BYTE     = 8'hA5;
  localparam logic [7:0] EOF_BYTE     = 8'h5A;
  localparam logic [7:0] CMD_MODE     = 8'h01;
  localparam logic [7:0] CMD_XMIN     = 8'h10;
  localparam logic [7:0] CMD_XMAX     = 8'h11;
  localparam logic [7:0] CMD_YMIN     = 8'h12;
  localparam logic [7:0] CMD_YMAX     = 8'h13;
  localparam logic [7:0] CMD_COORD_EN = 8'h14;

  typedef enum logic [2:0] {
    IDLE, GET_CMD, GET_D0, GET_D1, GET_CHK, GET_EOF
  } state_t;

  state_t        state_q, state_d;
  logic [7:0]    cmd_q, d0_q, d1_q, chk_q;
  logic [TW-1:0] tmo_q;
  logic [9:0]    val_c;
  logic          cmd_good_c, frame_good_c, expire_c, accept_c, reject_c;

  // Frame validation, evaluated while the EOF byte is on rx_data
  always_comb begin
    val_c      = {d0_q[1:0], d1_q};
    cmd_good_c = 1'b0;
    case (cmd_q)
      CMD_MODE, CMD_COORD_EN: cmd_good_c = 1'b1;
      CMD_XMIN, CMD_XMAX:
        cmd_good_c = (d0_q[7:2] == 6'd0) && ({1'b0, val_c} < 11'(X_LIMIT));
      CMD_YMIN, CMD_YMAX:
        cmd_good_c = (d0_q[7:2] == 6'd0) && ({1'b0, val_c} < 11'(Y_LIMIT));
      default: cmd_good_c = 1'b0;
    endcase
    frame_good_c = (rx_data == EOF_BYTE) && (chk_q == (cmd_q ^ d0_q ^ d1_q)) && cmd_good_c;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next state; a byte arriving on the expiry cycle takes priority over the timeout
  always_comb begin
    state_d  = state_q;
    accept_c = 1'b0;
    reject_c = 1'b0;
    expire_c = (state_q != IDLE) && !rx_done && (tmo_q == TW'(TIMEOUT_CYC - 1));
    if (rx_done) begin
      case (state_q)
        IDLE:    if (rx_data == SOF_BYTE) state_d = GET_CMD;
        GET_CMD: state_d = GET_D0;
        GET_D0:  state_d = GET_D1;
        GET_D1:  state_d = GET_CHK;
        GET_CHK: state_d = GET_EOF;
        GET_EOF: begin
          state_d  = IDLE;
          accept_c = frame_good_c;
          reject_c = !frame_good_c;
        end
        default: state_d = IDLE;
      endcase
    end else if (expire_c) begin
      state_d  = IDLE;
      reject_c = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cmd_q        <= '0;
      d0_q         <= '0;
      d1_q         <= '0;
      chk_q        <= '0;
      tmo_q        <= '0;
      cmd_ok       <= 1'b0;
      cmd_err      <= 1'b0;
      err_count    <= '0;
      traffic_sel  <= 1'b0;
      sw_sel       <= 1'b0;
      manual_en    <= 1'b0;
      manual_light <= 1'b0;
      coord_ovr_en <= 1'b0;
      x_min_ovr    <= '0;
      x_max_ovr    <= '0;
      y_min_ovr    <= '0;
      y_max_ovr    <= '0;
    end else begin
      if (rx_done) begin
        case (state_q)
          GET_CMD: cmd_q <= rx_data;
          GET_D0:  d0_q  <= rx_data;
          GET_D1:  d1_q  <= rx_data;
          GET_CHK: chk_q <= rx_data;
          default: ;
        endcase
      end

      if (state_q == IDLE || rx_done) tmo_q <= '0;
      else                            tmo_q <= tmo_q + TW'(1);

      cmd_ok  <= accept_c;
      cmd_err <= reject_c;
      if (reject_c && err_count != 8'hFF) err_count <= err_count + 8'd1;

      if (accept_c) begin
        case (cmd_q)
          CMD_MODE: begin
            traffic_sel  <= d0_q[0];
            sw_sel       <= d0_q[1];
            manual_en    <= d0_q[2];
            manual_light <= d0_q[3];
          end
          CMD_XMIN:     x_min_ovr    <= val_c;
          CMD_XMAX:     x_max_ovr    <= val_c;
          CMD_YMIN:     y_min_ovr    <= val_c;
          CMD_YMAX:     y_max_ovr    <= val_c;
          CMD_COORD_EN: coord_ovr_en <= d0_q[0];
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Scoreboard bench for uart_cmd_parser: each frame pushes its predicted outcome,
// and every cmd_ok/cmd_err pulse pops and compares it.
module tb_uart_cmd_parser;

  localparam int unsigned T = 40;

  logic       clk = 1'b0;
  logic       reset;
  logic       rx_done;
  logic [7:0] rx_data;
  logic       traffic_sel, sw_sel, manual_en, manual_light, coord_ovr_en;
  logic [9:0] x_min_ovr, x_max_ovr, y_min_ovr, y_max_ovr;
  logic       cmd_ok, cmd_err;
  logic [7:0] err_count;
  logic [44:0] dut_cfg;

  uart_cmd_parser #(.TIMEOUT_CYC(T), .X_LIMIT(320), .Y_LIMIT(240)) dut (
    .clk(clk), .reset(reset), .rx_done(rx_done), .rx_data(rx_data),
    .traffic_sel(traffic_sel), .sw_sel(sw_sel), .manual_en(manual_en),
    .manual_light(manual_light), .coord_ovr_en(coord_ovr_en),
    .x_min_ovr(x_min_ovr), .x_max_ovr(x_max_ovr),
    .y_min_ovr(y_min_ovr), .y_max_ovr(y_max_ovr),
    .cmd_ok(cmd_ok), .cmd_err(cmd_err), .err_count(err_count)
  );

  always #5 clk = ~clk;

  assign dut_cfg = {traffic_sel, sw_sel, manual_en, manual_light, coord_ovr_en,
                    x_min_ovr, x_max_ovr, y_min_ovr, y_max_ovr};

  typedef struct {
    bit          ok;
    logic [44:0] cfg;
    logic [7:0]  errc;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  logic       m_tr, m_sw, m_me, m_ml, m_coe;
  logic [9:0] m_xmin, m_xmax, m_ymin, m_ymax;
  logic [7:0] m_errc;

  function automatic logic [44:0] model_cfg();
    return {m_tr, m_sw, m_me, m_ml, m_coe, m_xmin, m_xmax, m_ymin, m_ymax};
  endfunction

  task automatic model_reset();
    {m_tr, m_sw, m_me, m_ml, m_coe} = '0;
    {m_xmin, m_xmax, m_ymin, m_ymax} = '0;
    m_errc = '0;
  endtask

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic push_result(input bit good);
    exp_t e;
    if (!good && m_errc != 8'hFF) m_errc = m_errc + 8'd1;
    e.ok   = good;
    e.cfg  = model_cfg();
    e.errc = m_errc;
    exp_q.push_back(e);
  endtask

  // Predicts the outcome of frame A5 c d0 d1 chk eof and updates the model
  task automatic predict(input logic [7:0] c, input logic [7:0] d0, input logic [7:0] d1,
                         input logic [7:0] chk, input logic [7:0] eof);
    bit good;
    logic [9:0] v;
    v    = {d0[1:0], d1};
    good = (eof == 8'h5A) && (chk == (c ^ d0 ^ d1));
    if (good) begin
      case (c)
        8'h01: begin m_tr = d0[0]; m_sw = d0[1]; m_me = d0[2]; m_ml = d0[3]; end
        8'h10: if (d0[7:2] == 6'd0 && v < 10'd320) m_xmin = v; else good = 0;
        8'h11: if (d0[7:2] == 6'd0 && v < 10'd320) m_xmax = v; else good = 0;
        8'h12: if (d0[7:2] == 6'd0 && v < 10'd240) m_ymin = v; else good = 0;
        8'h13: if (d0[7:2] == 6'd0 && v < 10'd240) m_ymax = v; else good = 0;
        8'h14: m_coe = d0[0];
        default: good = 0;
      endcase
    end
    push_result(good);
  endtask

  // Advance to the next falling edge and score any pulse present there
  task automatic tick();
    exp_t e;
    @(negedge clk);
    if (cmd_ok || cmd_err) begin
      if (exp_q.size() == 0) begin
        check("unexpected_pulse", 64'({cmd_ok, cmd_err}), 64'(0));
      end else begin
        e = exp_q.pop_front();
        check("pulse_kind", 64'({cmd_ok, cmd_err}), 64'({e.ok, !e.ok}));
        check("cfg", 64'(dut_cfg), 64'(e.cfg));
        check("err_count", 64'(err_count), 64'(e.errc));
      end
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data = b;
    rx_done = 1'b1;
    tick();
    rx_done = 1'b0;
    rx_data = 8'h00;
  endtask

  task automatic frame(input logic [7:0] c, input logic [7:0] d0, input logic [7:0] d1,
                       input logic [7:0] chk, input logic [7:0] eof);
    predict(c, d0, d1, chk, eof);
    send_byte(8'hA5);
    send_byte(c);
    send_byte(d0);
    send_byte(d1);
    send_byte(chk);
    send_byte(eof);
    check("latency", 64'(cmd_ok | cmd_err), 64'(1));
    tick();
    check("pulse_width", 64'(cmd_ok | cmd_err), 64'(0));
  endtask

  initial begin
    reset   = 1'b1;
    rx_done = 1'b0;
    rx_data = 8'h00;
    model_reset();
    tick();
    tick();
    check("reset_cfg", 64'(dut_cfg), 64'(0));
    check("reset_errc", 64'(err_count), 64'(0));
    check("reset_pulses", 64'({cmd_ok, cmd_err}), 64'(0));
    reset = 1'b0;
    tick();

    // MODE frame
    frame(8'h01, 8'h0B, 8'h00, 8'h0A, 8'h5A);
    check("mode_bits", 64'({traffic_sel, sw_sel, manual_en, manual_light}), 64'(4'b1101));
    check("mode_errc", 64'(err_count), 64'(0));

    // x_max at and beyond the limit
    frame(8'h11, 8'h01, 8'h3F, 8'h2F, 8'h5A);
    check("xmax_319", 64'(x_max_ovr), 64'(319));
    frame(8'h11, 8'h01, 8'h40, 8'h50, 8'h5A);
    check("xmax_hold", 64'(x_max_ovr), 64'(319));
    check("xmax_errc", 64'(err_count), 64'(1));

    // y boundary, reserved D0 bits, unknown command
    frame(8'h13, 8'h00, 8'hEF, 8'hFC, 8'h5A);
    check("ymax_239", 64'(y_max_ovr), 64'(239));
    frame(8'h12, 8'h00, 8'hF0, 8'hE2, 8'h5A);
    frame(8'h10, 8'h04, 8'h05, 8'h11, 8'h5A);
    frame(8'h10, 8'h00, 8'h05, 8'h15, 8'h5A);
    check("xmin_5", 64'(x_min_ovr), 64'(5));
    frame(8'h22, 8'h00, 8'h00, 8'h22, 8'h5A);

    // Bad checksum, then recovery
    frame(8'h01, 8'h0B, 8'h00, 8'h0B, 8'h5A);
    check("badchk_mode", 64'({traffic_sel, sw_sel, manual_en, manual_light}), 64'(4'b1101));
    frame(8'h01, 8'h04, 8'h00, 8'h05, 8'h5A);
    check("recover_mode", 64'({traffic_sel, sw_sel, manual_en, manual_light}), 64'(4'b0010));

    // Inter-byte timeout
    send_byte(8'hA5);
    send_byte(8'h01);
    push_result(1'b0);
    repeat (T - 1) tick();
    check("no_early_timeout", 64'(cmd_err), 64'(0));
    tick();
    check("timeout_err", 64'(cmd_err), 64'(1));
    tick();
    frame(8'h01, 8'h0B, 8'h00, 8'h0A, 8'h5A);
    check("after_timeout", 64'({traffic_sel, sw_sel, manual_en, manual_light}), 64'(4'b1101));

    // Byte delivered on the expiry cycle wins
    predict(8'h01, 8'h04, 8'h00, 8'h05, 8'h5A);
    send_byte(8'hA5);
    send_byte(8'h01);
    repeat (T - 1) tick();
    send_byte(8'h04);
    send_byte(8'h00);
    send_byte(8'h05);
    send_byte(8'h5A);
    check("expiry_byte_ok", 64'({cmd_ok, cmd_err}), 64'(2'b10));
    tick();

    // Garbage in IDLE is silent
    send_byte(8'h00);
    send_byte(8'hFF);
    send_byte(8'h5A);
    repeat (3) tick();
    check("garbage_errc", 64'(err_count), 64'(m_errc));
    frame(8'h14, 8'h01, 8'h00, 8'h15, 8'h5A);
    check("coord_en", 64'(coord_ovr_en), 64'(1));

    // Error counter saturation
    for (int i = 0; i < 260; i++) frame(8'h01, 8'h0B, 8'h00, 8'h0A, 8'h00);
    check("err_sat", 64'(err_count), 64'(255));

    // Reset mid-frame
    send_byte(8'hA5);
    send_byte(8'h01);
    send_byte(8'h0B);
    reset = 1'b1;
    model_reset();
    tick();
    check("midreset_cfg", 64'(dut_cfg), 64'(0));
    check("midreset_errc", 64'(err_count), 64'(0));
    check("midreset_pulses", 64'({cmd_ok, cmd_err}), 64'(0));
    reset = 1'b0;
    tick();
    frame(8'h01, 8'h0B, 8'h00, 8'h0A, 8'h5A);
    check("post_reset_mode", 64'({traffic_sel, sw_sel, manual_en, manual_light}), 64'(4'b1101));
    check("post_reset_errc", 64'(err_count), 64'(0));

    repeat (3) tick();
    check("scoreboard_empty", 64'(exp_q.size()), 64'(0));
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/uart_cmd_parser.md
Name: uart_cmd_parser

Overview:
- Consumes the receive side of sender_uart (rx_done strobe, rx_pop_data byte) and decodes fixed-length command frames from the host PC.
- Drives runtime configuration into the design: Signal_CU traffic_sel, Decision_CrossWalk sw_sel, a manual traffic-light override, and a crosswalk-coordinate override.
- Also reports frame accept/reject strobes and a saturating error counter.

Parameters:
- TIMEOUT_CYC, 1_000_000, max clk cycles allowed between bytes of one frame (10 ms at 100 MHz).
- X_LIMIT, 320, exclusive upper bound for x coordinates (QVGA width).
- Y_LIMIT, 240, exclusive upper bound for y coordinates (QVGA height).

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- rx_done  in  1  one-cycle strobe: rx_data holds a new byte
- rx_data  in  8  received byte
- traffic_sel  out  1  Signal_CU timing-table select
- sw_sel  out  1  Decision_CrossWalk mode select
- manual_en  out  1  manual light override enable
- manual_light  out  1  forced light value (0 = green, 1 = red)
- coord_ovr_en  out  1  use override coordinates instead of detected ones
- x_min_ovr, x_max_ovr, y_min_ovr, y_max_ovr  out  10 each  override coordinates
- cmd_ok  out  1  one-cycle pulse: frame accepted and applied
- cmd_err  out  1  one-cycle pulse: frame rejected
- err_count  out  8  saturating count of cmd_err pulses

Behaviour:
- Clock and reset: one clock, clk. reset is asynchronous and active-high. All registers and outputs clear to 0 on reset, including the FSM (IDLE), timeout counter, and shadow byte registers.
- Frame format, 6 bytes: SOF = 0xA5, CMD, D0, D1, CHK, EOF = 0x5A. CHK = CMD ^ D0 ^ D1.
- FSM states: IDLE, GET_CMD, GET_D0, GET_D1, GET_CHK, GET_EOF.
  - The FSM advances only on cycles where rx_done = 1.
  - IDLE goes to GET_CMD only on byte 0xA5. Any other byte is silently dropped: no error.
  - Inside a frame, 0xA5 is ordinary data; there is no resync.
- Completion: the frame completes on the rx_done that carries the EOF byte. The checks are, in order:
  - EOF byte equals 0x5A
  - CHK matches
  - CMD is valid
  - the value is in range
- Accepted frame: config registers update and cmd_ok = 1 on the next clk edge, i.e. 1-cycle latency from the EOF rx_done. The FSM returns to IDLE.
- Rejected frame: cmd_err pulses with the same timing, no config register changes, and the FSM returns to IDLE.
- Commands:
  - 0x01 MODE: D0[0] → traffic_sel, D0[1] → sw_sel, D0[2] → manual_en, D0[3] → manual_light. D0[7:4] and D1 are ignored.
  - 0x10 / 0x11 / 0x12 / 0x13: set x_min / x_max / y_min / y_max override. Value = {D0[1:0], D1}. D0[7:2] must be 0, otherwise error.
  - x range check: value < X_LIMIT. y range check: value < Y_LIMIT. Out of range is an error and the register is unchanged.
  - 0x14 COORD_EN: D0[0] → coord_ovr_en.
  - Any other CMD is an error.
  - No min ≤ max cross-check; each field is independent.
- Timeout:
  - Counter reloads to 0 on every rx_done and is held at 0 in IDLE.
  - In any non-IDLE state, when the counter reaches TIMEOUT_CYC-1 with no rx_done: cmd_err pulses and the FSM returns to IDLE.
  - If rx_done coincides with expiry, the byte wins: it is processed normally and there is no error.
- err_count increments on each cmd_err and saturates at 255.
- cmd_ok and cmd_err are never high in the same cycle.
- Reset mid-frame: FSM goes to IDLE and the partial frame is discarded. Config registers return to 0.

Test Plan:
- MODE frame A5 01 0B 00 0A 5A → traffic_sel = 1, sw_sel = 1, manual_en = 0, manual_light = 1. cmd_ok pulses exactly 1 cycle after the final rx_done. err_count = 0.
- Coordinate frame A5 11 01 3F 2F 5A → x_max_ovr = 319, cmd_ok. Then A5 11 01 40 50 5A (value 320) → cmd_err, x_max_ovr stays 319, err_count = 1.
- Bad checksum A5 01 0B 00 0B 5A → cmd_err, all MODE outputs unchanged. A following valid frame is accepted, showing recovery.
- Timeout:
  - Send A5 01, then wait TIMEOUT_CYC cycles → cmd_err and FSM in IDLE. Then send the full MODE frame → accepted.
  - Separately, deliver a byte on exactly the expiry cycle → no error.
- Garbage bytes 00 FF 5A in IDLE → no pulses. Then A5 14 01 00 15 5A → coord_ovr_en = 1.
- 260 bad-EOF frames → err_count = 255 (saturated). Asserting reset after A5 01 0B → all outputs 0. A fresh frame after reset decodes correctly.
